// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares one GMII TX port between ARP, ICMP and UDP
// generators with a registered byte mux, an inter-frame gap and a
// frame watchdog. Macro ETH_TX_RR_EN selects round-robin arbitration
// (default: fixed priority ARP > ICMP > UDP).
// Ports: clk, rst_n (sync, active-low); per source *_req in, *_gnt out,
// *_done in, *_gmii_tx_en/*_gmii_txd in; shared gmii_tx_en/gmii_txd out,
// tx_busy out, tx_timeout out.
module eth_tx_arbiter #(
  parameter int unsigned IFG_CYCLES       = 12,
  parameter int unsigned MAX_FRAME_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arp_req,
  input  logic       icmp_req,
  input  logic       udp_req,
  output logic       arp_gnt,
  output logic       icmp_gnt,
  output logic       udp_gnt,
  input  logic       arp_done,
  input  logic       icmp_done,
  input  logic       udp_done,
  input  logic       arp_gmii_tx_en,
  input  logic       icmp_gmii_tx_en,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic [7:0] icmp_gmii_txd,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       tx_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_IFG
  } state_t;

  localparam logic [15:0] LP_WD_LAST  = 16'(MAX_FRAME_CYCLES - 1);
  localparam logic [7:0]  LP_IFG_LAST = 8'(IFG_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sel;
  logic [15:0] r_cnt;
  logic [7:0]  r_ifg;
  logic        r_tx_en;
  logic [7:0]  r_txd;

  logic [3:0]  w_req;
  logic        w_any;
  logic [1:0]  w_win;
  logic        w_sel_en;
  logic [7:0]  w_sel_txd;
  logic        w_sel_done;
  logic        w_wd_hit;

  // Source codes: 0 ARP, 1 ICMP, 2 UDP. Bit 3 pads the vector so a
  // 2-bit code always indexes inside it.
  assign w_req = {1'b0, udp_req, icmp_req, arp_req};
  assign w_any = |w_req;

  function automatic logic [1:0] f_pick(
    input logic [3:0] req,
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] c
  );
    if (req[a]) return a;
    if (req[b]) return b;
    return c;
  endfunction

`ifdef ETH_TX_RR_EN
  // Last granted source; search begins at the one after it.
  logic [1:0] r_ptr;

  always_comb begin
    w_win = 2'd0;
    unique case (r_ptr)
      2'd0:    w_win = f_pick(w_req, 2'd1, 2'd2, 2'd0);
      2'd1:    w_win = f_pick(w_req, 2'd2, 2'd0, 2'd1);
      default: w_win = f_pick(w_req, 2'd0, 2'd1, 2'd2);
    endcase
  end
`else
  assign w_win = f_pick(w_req, 2'd0, 2'd1, 2'd2);
`endif

  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_txd  = 8'h00;
    w_sel_done = 1'b0;
    unique case (r_sel)
      2'd0: begin
        w_sel_en   = arp_gmii_tx_en;
        w_sel_txd  = arp_gmii_txd;
        w_sel_done = arp_done;
      end
      2'd1: begin
        w_sel_en   = icmp_gmii_tx_en;
        w_sel_txd  = icmp_gmii_txd;
        w_sel_done = icmp_done;
      end
      2'd2: begin
        w_sel_en   = udp_gmii_tx_en;
        w_sel_txd  = udp_gmii_txd;
        w_sel_done = udp_done;
      end
      default: ;
    endcase
  end

  assign w_wd_hit = (r_cnt == LP_WD_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_GRANT;
      S_GRANT: w_next = S_BUSY;
      S_BUSY:  if (w_sel_done || w_wd_hit) w_next = S_IFG;
      S_IFG:   if (r_ifg == LP_IFG_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_cnt   <= 16'd0;
      r_ifg   <= 8'd0;
      r_tx_en <= 1'b0;
      r_txd   <= 8'h00;
`ifdef ETH_TX_RR_EN
      r_ptr   <= 2'd0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) r_sel <= w_win;
      if (r_state == S_GRANT) r_cnt <= 16'd0;
      else if (r_state == S_BUSY) r_cnt <= r_cnt + 16'd1;
      // Cleared in every other state so each gap starts from zero.
      if (r_state == S_IFG) r_ifg <= r_ifg + 8'd1;
      else r_ifg <= 8'd0;
      if (r_state == S_BUSY) begin
        r_tx_en <= w_sel_en;
        r_txd   <= w_sel_txd;
      end else begin
        r_tx_en <= 1'b0;
        r_txd   <= 8'h00;
      end
`ifdef ETH_TX_RR_EN
      if (r_state == S_GRANT) r_ptr <= r_sel;
`endif
    end
  end

  assign arp_gnt    = (r_state == S_GRANT) && (r_sel == 2'd0);
  assign icmp_gnt   = (r_state == S_GRANT) && (r_sel == 2'd1);
  assign udp_gnt    = (r_state == S_GRANT) && (r_sel == 2'd2);
  assign gmii_tx_en = r_tx_en;
  assign gmii_txd   = r_txd;
  assign tx_busy    = (r_state != S_IDLE);
  // Done on the last allowed cycle ends the frame normally.
  assign tx_timeout = (r_state == S_BUSY) && w_wd_hit && !w_sel_done;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed self-checking bench for eth_tx_arbiter
// (IFG_CYCLES=12, MAX_FRAME_CYCLES=100).
module tb_eth_tx_arbiter;

  localparam int IFG = 12;
  localparam int MAXF = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arp_req = 0, icmp_req = 0, udp_req = 0;
  logic       arp_gnt, icmp_gnt, udp_gnt;
  logic       arp_done = 0, icmp_done = 0, udp_done = 0;
  logic       arp_gmii_tx_en = 0, icmp_gmii_tx_en = 0, udp_gmii_tx_en = 0;
  logic [7:0] arp_gmii_txd = 0, icmp_gmii_txd = 0, udp_gmii_txd = 0;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       tx_busy;
  logic       tx_timeout;

  int n_total = 0;
  int n_bad = 0;
  int cyc_n = 0;

  eth_tx_arbiter #(
    .IFG_CYCLES(IFG),
    .MAX_FRAME_CYCLES(MAXF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arp_req(arp_req),
    .icmp_req(icmp_req),
    .udp_req(udp_req),
    .arp_gnt(arp_gnt),
    .icmp_gnt(icmp_gnt),
    .udp_gnt(udp_gnt),
    .arp_done(arp_done),
    .icmp_done(icmp_done),
    .udp_done(udp_done),
    .arp_gmii_tx_en(arp_gmii_tx_en),
    .icmp_gmii_tx_en(icmp_gmii_tx_en),
    .udp_gmii_tx_en(udp_gmii_tx_en),
    .arp_gmii_txd(arp_gmii_txd),
    .icmp_gmii_txd(icmp_gmii_txd),
    .udp_gmii_txd(udp_gmii_txd),
    .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd),
    .tx_busy(tx_busy),
    .tx_timeout(tx_timeout)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, arp_gnt, icmp_gnt, udp_gnt, gmii_tx_en, gmii_txd,
            tx_busy, tx_timeout};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    arp_gmii_tx_en = 0; arp_gmii_txd = 0; arp_done = 0;
    icmp_gmii_tx_en = 0; icmp_gmii_txd = 0; icmp_done = 0;
    udp_gmii_tx_en = 0; udp_gmii_txd = 0; udp_done = 0;
  endtask

  task automatic drv(input int src, input logic en, input logic [7:0] d,
                     input logic dn);
    case (src)
      0: begin arp_gmii_tx_en = en; arp_gmii_txd = d; arp_done = dn; end
      1: begin icmp_gmii_tx_en = en; icmp_gmii_txd = d; icmp_done = dn; end
      default: begin
        udp_gmii_tx_en = en; udp_gmii_txd = d; udp_done = dn;
      end
    endcase
  endtask

  task automatic wait_gnt(input int limit, output int who, output int at);
    who = -1;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      cyc();
      mid();
      if (arp_gnt || icmp_gnt || udp_gnt) begin
        who = arp_gnt ? 0 : (icmp_gnt ? 1 : 2);
        at = cyc_n;
        if (arp_gnt) arp_req = 0;
        if (icmp_gnt) icmp_req = 0;
        if (udp_gnt) udp_req = 0;
        break;
      end
    end
  endtask

  task automatic send(input int src, input int len, output int dn);
    for (int k = 0; k < len; k++) begin
      cyc();
      clr();
      drv(src, 1'b1, 8'(160 + k), k == len - 1);
      mid();
    end
    dn = cyc_n;
    cyc();
    clr();
    mid();
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!tx_busy) break;
      cyc();
      mid();
    end
    check("idle", 32'(tx_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int who, at, dn, d0, pulses, pk, ag;
    int exp_p[3];
    int exp_r[4];
`ifdef ETH_TX_RR_EN
    exp_p = '{2, 0, 1};
    exp_r = '{2, 0, 2, 0};
`else
    exp_p = '{0, 1, 2};
    exp_r = '{0, 0, 0, 0};
`endif

    // Reset state
    cyc(); cyc(); mid();
    check("reset_outs", outs(), 0);
    cyc(); rst_n = 1; mid();
    check("idle_outs", outs(), 0);

    // Single ICMP frame, 64 bytes
    cyc(); icmp_req = 1; mid();
    check("icmp_pre_gnt", 32'(icmp_gnt), 0);
    cyc(); mid();
    check("icmp_gnt", {29'd0, arp_gnt, icmp_gnt, udp_gnt}, 32'b010);
    check("busy_grant", 32'(tx_busy), 1);
    icmp_req = 0;
    for (int k = 0; k < 64; k++) begin
      cyc();
      drv(1, 1'b1, 8'(k), k == 63);
      mid();
      if (k > 0)
        check("icmp_byte", {23'd0, gmii_tx_en, gmii_txd}, 32'h100 + k - 1);
    end
    d0 = cyc_n;
    cyc(); clr(); mid();
    check("icmp_last", {23'd0, gmii_tx_en, gmii_txd}, 32'h13F);
    cyc(); mid();
    check("gmii_zero_d2", {23'd0, gmii_tx_en, gmii_txd}, 0);
    for (int i = 0; i < IFG - 2; i++) begin cyc(); mid(); end
    check("busy_end_ifg", 32'(tx_busy), 1);
    cyc(); mid(); cyc(); mid();
    check("busy_fall", 32'(tx_busy), 0);
    check("busy_fall_at", cyc_n - d0, IFG + 2);

    // Simultaneous requests
    cyc(); arp_req = 1; icmp_req = 1; udp_req = 1; mid();
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(60, who, at);
      check("prio_who", who, exp_p[i]);
      if (i > 0) check("ifg_gap", at - dn, IFG + 2);
      send(who < 0 ? 0 : who, 4, dn);
    end
    wait_idle(40);

    // Stray done and tx_en from ARP while ICMP is busy
    cyc(); icmp_req = 1; mid();
    wait_gnt(10, who, at);
    check("stray_who", who, 1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      clr();
      drv(1, 1'b1, 8'(8'h50 + k), k == 7);
      arp_gmii_tx_en = 1;
      arp_gmii_txd = 8'hFF;
      arp_done = (k == 2);
      mid();
      if (k > 0)
        check("stray_data", {23'd0, gmii_tx_en, gmii_txd}, 32'h150 + k - 1);
    end
    cyc(); clr(); mid();
    check("stray_last", {23'd0, gmii_tx_en, gmii_txd}, 32'h157);
    wait_idle(40);

    // Watchdog: UDP never signals done, ARP waits
    cyc(); udp_req = 1; mid();
    wait_gnt(10, who, at);
    check("wd_who", who, 2);
    arp_req = 1;
    pulses = 0; pk = 0; ag = 0;
    for (int k = 1; k <= 130; k++) begin
      cyc();
      drv(2, 1'b1, 8'h77, 1'b0);
      mid();
      if (tx_timeout) begin pulses++; pk = k; end
      if (k == 102) check("wd_txen_off", 32'(gmii_tx_en), 0);
      if (arp_gnt) begin ag = k; arp_req = 0; break; end
    end
    check("wd_pulses", pulses, 1);
    check("wd_cycle", pk, MAXF);
    check("wd_arp_gnt", ag, MAXF + IFG + 2);
    clr();
    send(0, 2, dn);
    wait_idle(40);

    // Mid-frame reset with ICMP request held
    cyc(); icmp_req = 1; mid();
    wait_gnt(10, who, at);
    icmp_req = 1;
    cyc(); drv(1, 1'b1, 8'h11, 1'b0); mid();
    cyc(); mid();
    check("rst_pre_data", {23'd0, gmii_tx_en, gmii_txd}, 32'h111);
    cyc(); rst_n = 0; mid();
    cyc(); rst_n = 1; clr(); mid();
    check("rst_outs", outs(), 0);
    cyc(); mid();
    check("rst_regnt", {29'd0, arp_gnt, icmp_gnt, udp_gnt}, 32'b010);
    icmp_req = 0;
    send(1, 2, dn);
    wait_idle(40);

    // ARP and UDP re-request after every frame
    cyc(); arp_req = 1; udp_req = 1; mid();
    for (int i = 0; i < 4; i++) begin
      wait_gnt(60, who, at);
      check("rr_who", who, exp_r[i]);
      send(who < 0 ? 0 : who, 3, dn);
      if (who == 0) arp_req = 1;
      else udp_req = 1;
    end
    arp_req = 0;
    udp_req = 0;
    wait_idle(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
